// File: rtl/pipe_pkg.sv
// Shared types and constants for the fetch-PC path.
// Combinational definitions only; no state.
// No flow control.
package pipe_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } pc_state_e;

  // Redirect source indices, lower index = higher priority
  localparam int REDIR_TRAP = 0;
  localparam int REDIR_EX   = 1;
  localparam int REDIR_ID   = 2;

  localparam int NUM_REDIR_DEF = 3;

  typedef logic [$clog2(NUM_REDIR_DEF)-1:0] redir_idx_t;

endpackage

// File: rtl/pc_gen_if.sv
// Bundle of redirect inputs, stall control and PC outputs for pc_gen.
// Pure wiring; no latency.
// update_n is the only stall qualifier; there is no other backpressure.
interface pc_gen_if #(
  parameter int WIDTH     = 32,
  parameter int NUM_REDIR = 3
);

  logic                              update_n;
  logic [NUM_REDIR-1:0]              redir_valid;
  logic [NUM_REDIR-1:0][WIDTH-1:0]   redir_target;
  logic [WIDTH-1:0]                  pc_out;
  logic [WIDTH-1:0]                  pc_next;
  logic                              fetch_valid;
  logic                              redir_taken;
  logic                              misaligned;

  // Driver side: stall control and redirect requests
  modport master (
    output update_n, redir_valid, redir_target,
    input  pc_out, pc_next, fetch_valid, redir_taken, misaligned
  );

  // pc_gen side
  modport slave (
    input  update_n, redir_valid, redir_target,
    output pc_out, pc_next, fetch_valid, redir_taken, misaligned
  );

endinterface

// File: rtl/pc_gen_redirect_arbiter.sv
// Fixed-priority encoder and target mux over the redirect sources.
// Purely combinational, zero latency.
// No backpressure; the caller decides whether the winner is used.
module redirect_arbiter #(
  parameter int WIDTH     = 32,
  parameter int NUM_REDIR = 3,
  parameter int IW        = 2
) (
  input  logic [NUM_REDIR-1:0]            i_valid,
  input  logic [NUM_REDIR-1:0][WIDTH-1:0] i_target,
  output logic                            o_any_valid,
  output logic [IW-1:0]                   o_idx,
  output logic [WIDTH-1:0]                o_target
);

  // Scan from the lowest priority upward so the lowest set index is left last
  always_comb begin
    o_any_valid = 1'b0;
    o_idx       = '0;
    o_target    = '0;
    for (int i = NUM_REDIR - 1; i >= 0; i--) begin
      if (i_valid[i]) begin
        o_any_valid = 1'b1;
        o_idx       = IW'(i);
        o_target    = i_target[i];
      end
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC register with sequential increment and prioritised redirects.
// pc_out updates one edge after a redirect when unstalled; on the release edge when stalled.
// update_n=1 holds the PC; redirects seen during the hold are parked and applied on release.
module pc_gen
  import pipe_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int               INC          = 4,
  parameter int               NUM_REDIR    = 3,
  parameter int               ALIGN_BITS   = 2
) (
  input  logic     clk,
  input  logic     reset,
  pc_gen_if.slave  bus
);

  localparam int IW = (NUM_REDIR > 1) ? $clog2(NUM_REDIR) : 1;

  pc_state_e        r_state;
  logic [WIDTH-1:0] r_pc;
  logic             r_redir_taken;
  logic             r_misaligned;
  logic             r_pend_vld;
  logic [IW-1:0]    r_pend_idx;
  logic [WIDTH-1:0] r_pend_tgt;

  pc_state_e        w_state_nxt;
  logic [WIDTH-1:0] w_pc_nxt;
  logic             w_taken_nxt;
  logic             w_mis_nxt;
  logic             w_pend_vld_nxt;
  logic [IW-1:0]    w_pend_idx_nxt;
  logic [WIDTH-1:0] w_pend_tgt_nxt;

  logic             w_arb_any;
  logic [IW-1:0]    w_arb_idx;
  logic [WIDTH-1:0] w_arb_tgt;
  logic             w_live_wins;
  logic             w_win_vld;
  logic [WIDTH-1:0] w_win_tgt;

  redirect_arbiter #(
    .WIDTH     (WIDTH),
    .NUM_REDIR (NUM_REDIR),
    .IW        (IW)
  ) u_arb (
    .i_valid     (bus.redir_valid),
    .i_target    (bus.redir_target),
    .o_any_valid (w_arb_any),
    .o_idx       (w_arb_idx),
    .o_target    (w_arb_tgt)
  );

  // Live request beats the parked one on equal index, so a newer redirect from
  // the same stage supersedes the older one.
  assign w_live_wins = w_arb_any & (~r_pend_vld | (w_arb_idx <= r_pend_idx));
  assign w_win_vld   = w_arb_any | r_pend_vld;
  assign w_win_tgt   = w_live_wins ? w_arb_tgt : r_pend_tgt;

  // Next-state and next-PC selection; a hold always presents the current PC so
  // IMEM never sees the parked target before the stall releases.
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_taken_nxt    = 1'b0;
    w_mis_nxt      = r_misaligned;
    w_pend_vld_nxt = r_pend_vld;
    w_pend_idx_nxt = r_pend_idx;
    w_pend_tgt_nxt = r_pend_tgt;

    case (r_state)
      BOOT: begin
        w_state_nxt = RUN;
      end
      RUN, PEND: begin
        if (!bus.update_n) begin
          w_state_nxt = RUN;
          if (w_win_vld) begin
            w_pc_nxt       = w_win_tgt;
            w_taken_nxt    = 1'b1;
            w_mis_nxt      = |w_win_tgt[ALIGN_BITS-1:0];
            w_pend_vld_nxt = 1'b0;
          end else begin
            w_pc_nxt  = r_pc + WIDTH'(INC);
            w_mis_nxt = 1'b0;
          end
        end else begin
          if (w_arb_any) begin
            w_state_nxt = PEND;
          end
          if (w_live_wins) begin
            w_pend_vld_nxt = 1'b1;
            w_pend_idx_nxt = w_arb_idx;
            w_pend_tgt_nxt = w_arb_tgt;
          end
        end
      end
      default: begin
        w_state_nxt = BOOT;
      end
    endcase
  end

  // State, PC and parked-redirect registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= BOOT;
      r_pc          <= RESET_VECTOR;
      r_redir_taken <= 1'b0;
      r_misaligned  <= 1'b0;
      r_pend_vld    <= 1'b0;
      r_pend_idx    <= '0;
      r_pend_tgt    <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_redir_taken <= w_taken_nxt;
      r_misaligned  <= w_mis_nxt;
      r_pend_vld    <= w_pend_vld_nxt;
      r_pend_idx    <= w_pend_idx_nxt;
      r_pend_tgt    <= w_pend_tgt_nxt;
    end
  end

  assign bus.pc_out      = r_pc;
  assign bus.pc_next     = w_pc_nxt;
  assign bus.redir_taken = r_redir_taken;
  assign bus.misaligned  = r_misaligned;
  assign bus.fetch_valid = (r_state != BOOT) & ~r_misaligned;

endmodule

// File: tb/tb_pc_gen.sv
// Directed test of pc_gen: boot, increment, redirects, stalls, misalignment, reset.
// Outputs sampled 1 time unit after each rising edge.
// Stalls are driven through update_n.
module tb_pc_gen;
  import pipe_pkg::*;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  pc_gen_if #(.WIDTH(32), .NUM_REDIR(3)) bus ();

  pc_gen #(
    .WIDTH        (32),
    .RESET_VECTOR (32'h0),
    .INC          (4),
    .NUM_REDIR    (3),
    .ALIGN_BITS   (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic upd_n, input logic [2:0] vld,
                       input logic [31:0] t0, input logic [31:0] t1, input logic [31:0] t2);
    bus.update_n        = upd_n;
    bus.redir_valid     = vld;
    bus.redir_target[0] = t0;
    bus.redir_target[1] = t1;
    bus.redir_target[2] = t2;
  endtask

  task automatic idle_run();
    drive(1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    idle_run();

    // 1. reset and boot
    #12;
    chk("rst_pc", bus.pc_out, 32'h0);
    chk("rst_fv", {31'b0, bus.fetch_valid}, 32'h0);
    chk("rst_tk", {31'b0, bus.redir_taken}, 32'h0);
    chk("rst_mis", {31'b0, bus.misaligned}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    // redirect on the boot edge must be ignored
    drive(1'b0, 3'b010, 32'h0, 32'hDEAD_0000, 32'h0);
    tick();
    chk("boot_pc", bus.pc_out, 32'h0);
    chk("boot_fv", {31'b0, bus.fetch_valid}, 32'h1);
    chk("boot_tk", {31'b0, bus.redir_taken}, 32'h0);
    idle_run();
    tick(); chk("inc_4", bus.pc_out, 32'h4);
    tick(); chk("inc_8", bus.pc_out, 32'h8);
    tick(); chk("inc_c", bus.pc_out, 32'hC);

    // 2. EX beats ID
    drive(1'b0, 3'b110, 32'h0, 32'h100, 32'h200);
    #1 chk("prio_nxt", bus.pc_next, 32'h100);
    tick();
    chk("prio_pc", bus.pc_out, 32'h100);
    chk("prio_tk", {31'b0, bus.redir_taken}, 32'h1);
    idle_run();
    tick();
    chk("prio_inc", bus.pc_out, 32'h104);
    chk("prio_tk0", {31'b0, bus.redir_taken}, 32'h0);

    // 3. stalled: ID 0x200 then EX 0x300, release later
    drive(1'b1, 3'b100, 32'h0, 32'h0, 32'h200);
    tick();
    chk("st1_pc", bus.pc_out, 32'h104);
    drive(1'b1, 3'b010, 32'h0, 32'h300, 32'h0);
    tick();
    chk("st2_pc", bus.pc_out, 32'h104);
    drive(1'b1, 3'b000, 32'h0, 32'h0, 32'h0);
    #1 chk("st_nxt_hold", bus.pc_next, 32'h104);
    tick();
    chk("st3_pc", bus.pc_out, 32'h104);
    chk("st3_tk", {31'b0, bus.redir_taken}, 32'h0);
    idle_run();
    #1 chk("rel_nxt", bus.pc_next, 32'h300);
    tick();
    chk("rel_pc", bus.pc_out, 32'h300);
    chk("rel_tk", {31'b0, bus.redir_taken}, 32'h1);
    tick();
    chk("rel_inc", bus.pc_out, 32'h304);

    // 4a. parked EX vs live TRAP on release
    drive(1'b1, 3'b010, 32'h0, 32'h300, 32'h0);
    tick();
    drive(1'b0, 3'b001, 32'h80, 32'h0, 32'h0);
    tick();
    chk("trap_pc", bus.pc_out, 32'h80);
    idle_run();
    tick();
    chk("trap_inc", bus.pc_out, 32'h84);
    // 4b. parked EX vs live ID on release
    drive(1'b1, 3'b010, 32'h0, 32'h300, 32'h0);
    tick();
    drive(1'b0, 3'b100, 32'h0, 32'h0, 32'h400);
    tick();
    chk("pend_pc", bus.pc_out, 32'h300);
    idle_run();
    tick();
    chk("pend_inc", bus.pc_out, 32'h304);
    // 4c. same index: live request supersedes parked one
    drive(1'b1, 3'b010, 32'h0, 32'h300, 32'h0);
    tick();
    drive(1'b0, 3'b010, 32'h0, 32'h600, 32'h0);
    tick();
    chk("tie_pc", bus.pc_out, 32'h600);
    idle_run();

    // 5. misalignment and wrap
    drive(1'b0, 3'b010, 32'h0, 32'h102, 32'h0);
    tick();
    chk("mis_pc", bus.pc_out, 32'h102);
    chk("mis_flag", {31'b0, bus.misaligned}, 32'h1);
    chk("mis_fv", {31'b0, bus.fetch_valid}, 32'h0);
    idle_run();
    tick();
    chk("mis_inc", bus.pc_out, 32'h106);
    chk("mis_clr", {31'b0, bus.misaligned}, 32'h0);
    chk("mis_fv1", {31'b0, bus.fetch_valid}, 32'h1);
    drive(1'b0, 3'b001, 32'hFFFF_FFFC, 32'h0, 32'h0);
    tick();
    chk("wrap_top", bus.pc_out, 32'hFFFF_FFFC);
    idle_run();
    tick();
    chk("wrap_0", bus.pc_out, 32'h0);

    // 6. reset mid-stall with a parked redirect
    drive(1'b1, 3'b010, 32'h0, 32'h500, 32'h0);
    tick();
    drive(1'b1, 3'b000, 32'h0, 32'h0, 32'h0);
    reset = 1'b1;
    #1;
    chk("mrst_pc", bus.pc_out, 32'h0);
    chk("mrst_fv", {31'b0, bus.fetch_valid}, 32'h0);
    tick();
    @(negedge clk);
    reset = 1'b0;
    idle_run();
    tick();
    chk("mrst_boot", bus.pc_out, 32'h0);
    chk("mrst_fv1", {31'b0, bus.fetch_valid}, 32'h1);
    tick();
    chk("mrst_inc", bus.pc_out, 32'h4);
    chk("mrst_tk", {31'b0, bus.redir_taken}, 32'h0);
    tick();
    chk("mrst_inc2", bus.pc_out, 32'h8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
